// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared state encoding and width helper for the auto-sequencing mux
package mux_seq_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// rtl/mux_n_1.sv - combinational N:1 word selector, out = frame[sel]
module mux_n_1
    import mux_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    localparam int SEL_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH*DATA_W-1:0] frame_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [DATA_W-1:0]        data_o
);

    // Out-of-range selects shift the frame away entirely and yield zero.
    assign data_o = DATA_W'(frame_i >> (int'(sel_i) * DATA_W));

endmodule

// File: rtl/mux_n_seq.sv
// rtl/mux_n_seq.sv - captures an NUM_CH-word frame and replays it one word per beat; MUX_SEQ_MASK_EN adds ch_mask
module mux_n_seq
    import mux_seq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 4,
    parameter int ORDER_DESC = 0,
    localparam int SEL_W     = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
`ifdef MUX_SEQ_MASK_EN
    input  logic [NUM_CH-1:0]        ch_mask,
`endif
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_done
);

    logic [0:0]               state_q, state_d;
    logic [SEL_W-1:0]         idx_q, idx_d;
    logic [NUM_CH*DATA_W-1:0] frame_q, frame_d;
    logic                     done_q, done_d;
    logic [NUM_CH-1:0]        scan_mask;
    logic [NUM_CH-1:0]        scan_ord;
    logic [NUM_CH-1:0]        scan_sh;

`ifdef MUX_SEQ_MASK_EN
    logic [NUM_CH-1:0] mask_q, mask_d;
    // While idle the incoming mask decides the first channel of the frame being captured.
    assign scan_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;
`else
    assign scan_mask = '1;
`endif

    // Positions count in emission order; the mapping is its own inverse.
    function automatic int to_phys(input int pos);
        return (ORDER_DESC != 0) ? (NUM_CH - 1 - pos) : pos;
    endfunction

    assign scan_ord = (ORDER_DESC != 0) ? {<<{scan_mask}} : scan_mask;

    int   cur_pos, first_pos, next_pos, last_pos;
    logic any_en, has_next;

    always_comb begin
        cur_pos   = to_phys(int'(idx_q));
        first_pos = 0;
        next_pos  = 0;
        last_pos  = 0;
        any_en    = 1'b0;
        has_next  = 1'b0;
        scan_sh   = '0;
        for (int p = 0; p < NUM_CH; p++) begin
            scan_sh = scan_ord >> p;
            if (scan_sh[0]) begin
                if (!any_en) first_pos = p;
                any_en   = 1'b1;
                last_pos = p;
                if ((p > cur_pos) && !has_next) begin
                    next_pos = p;
                    has_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        done_d  = 1'b0;
`ifdef MUX_SEQ_MASK_EN
        mask_d  = mask_q;
`endif
        if (state_q == ST_IDLE) begin
            if (in_valid) begin
                frame_d = in_data;
`ifdef MUX_SEQ_MASK_EN
                mask_d  = ch_mask;
`endif
                if (any_en) begin
                    idx_d   = SEL_W'(to_phys(first_pos));
                    state_d = ST_STREAM;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (out_ready) begin
            if (cur_pos == last_pos) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = SEL_W'(to_phys(next_pos));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
`ifdef MUX_SEQ_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            done_q  <= done_d;
`ifdef MUX_SEQ_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    mux_n_1 #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_mux (
        .frame_i (frame_q),
        .sel_i   (idx_q),
        .data_o  (out_data)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_STREAM);
    assign out_sel    = idx_q;
    assign out_last   = (state_q == ST_STREAM) && (cur_pos == last_pos);
    assign frame_done = done_q;

endmodule

// File: tb/tb_mux_n_seq.sv
// tb/tb_mux_n_seq.sv - ascending and descending instances checked against a beat-list model
module tb_mux_n_seq;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam logic [N*DW-1:0] FRAME_A = {16'h0000, 16'h0100, 16'h0200, 16'h0300};
    localparam logic [N*DW-1:0] FRAME_B = {16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd};

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*DW-1:0] in_data = FRAME_A;
    logic          in_valid  = 1'b1;
    logic          out_ready = 1'b1;
`ifdef MUX_SEQ_MASK_EN
    logic [N-1:0]  ch_mask = 4'b1111;
`endif

    logic          in_ready   [2];
    logic          out_valid  [2];
    logic          out_last   [2];
    logic          frame_done [2];
    logic [DW-1:0] out_data   [2];
    logic [1:0]    out_sel    [2];

    always #5 clock = ~clock;

    mux_n_seq #(.DATA_W(DW), .NUM_CH(N), .ORDER_DESC(0)) dut_asc (
        .clock(clock), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_SEQ_MASK_EN
        .ch_mask(ch_mask),
`endif
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_sel(out_sel[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_last(out_last[0]),
        .frame_done(frame_done[0])
    );

    mux_n_seq #(.DATA_W(DW), .NUM_CH(N), .ORDER_DESC(1)) dut_desc (
        .clock(clock), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_SEQ_MASK_EN
        .ch_mask(ch_mask),
`endif
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_sel(out_sel[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_last(out_last[1]),
        .frame_done(frame_done[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each captured frame becomes a list of beats in emission order.
    logic [DW-1:0] m_data [2][N];
    int            m_sel  [2][N];
    int            m_cnt  [2] = '{0, 0};
    int            m_pos  [2] = '{0, 0};
    bit            m_busy [2] = '{0, 0};
    bit            m_done [2] = '{0, 0};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_cnt[i]  = 0;
            m_pos[i]  = 0;
        end
    endtask

    task automatic model_update();
        logic [N-1:0] msk;
`ifdef MUX_SEQ_MASK_EN
        msk = ch_mask;
`else
        msk = '1;
`endif
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit nd;
            int ch;
            nd = 1'b0;
            if (m_busy[i]) begin
                if (out_ready) begin
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == m_cnt[i]) begin
                        m_busy[i] = 1'b0;
                        nd        = 1'b1;
                    end
                end
            end else if (in_valid) begin
                m_cnt[i] = 0;
                m_pos[i] = 0;
                for (int p = 0; p < N; p++) begin
                    ch = (i == 1) ? (N - 1 - p) : p;
                    if (msk[ch]) begin
                        m_data[i][m_cnt[i]] = in_data[ch*DW +: DW];
                        m_sel[i][m_cnt[i]]  = ch;
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (m_cnt[i] == 0) nd = 1'b1;
                else m_busy[i] = 1'b1;
            end
            m_done[i] = nd;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    // Compare process: every falling edge, both instances.
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(!m_busy[i]));
            chk($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(m_busy[i]));
            chk($sformatf("frame_done[%0d]", i), int'(frame_done[i]), int'(m_done[i]));
            chk($sformatf("out_last[%0d]", i), int'(out_last[i]),
                int'(m_busy[i] && (m_pos[i] == m_cnt[i] - 1)));
            if (m_busy[i]) begin
                chk($sformatf("out_data[%0d]", i), int'(out_data[i]), int'(m_data[i][m_pos[i]]));
                chk($sformatf("out_sel[%0d]", i), int'(out_sel[i]), m_sel[i][m_pos[i]]);
            end
        end
    end

    // Log of accepted beats and done pulses, pinned against literals.
    logic [DW-1:0] log_data [2][16];
    int            log_sel  [2][16];
    bit            log_last [2][16];
    int            log_n    [2] = '{0, 0};
    int            done_cnt [2] = '{0, 0};

    initial forever begin
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            if (rst_n && out_valid[i] && out_ready && log_n[i] < 16) begin
                log_data[i][log_n[i]] = out_data[i];
                log_sel[i][log_n[i]]  = int'(out_sel[i]);
                log_last[i][log_n[i]] = out_last[i];
                log_n[i] = log_n[i] + 1;
            end
            if (rst_n && frame_done[i]) done_cnt[i] = done_cnt[i] + 1;
        end
    end

    task automatic clear_log();
        log_n    = '{0, 0};
        done_cnt = '{0, 0};
    endtask

    task automatic chk_beat(input string tag, input int i, input int k,
                            input int data, input int sel, input int last);
        chk($sformatf("%s_data[%0d][%0d]", tag, i, k), int'(log_data[i][k]), data);
        chk($sformatf("%s_sel[%0d][%0d]", tag, i, k), log_sel[i][k], sel);
        chk($sformatf("%s_last[%0d][%0d]", tag, i, k), int'(log_last[i][k]), last);
    endtask

    task automatic chk_frame_a(input string tag);
        chk({tag, "_count0"}, log_n[0], 4);
        chk({tag, "_count1"}, log_n[1], 4);
        chk({tag, "_done0"}, done_cnt[0], 1);
        chk({tag, "_done1"}, done_cnt[1], 1);
        chk_beat(tag, 0, 0, 'h0300, 0, 0);
        chk_beat(tag, 0, 1, 'h0200, 1, 0);
        chk_beat(tag, 0, 2, 'h0100, 2, 0);
        chk_beat(tag, 0, 3, 'h0000, 3, 1);
        chk_beat(tag, 1, 0, 'h0000, 3, 0);
        chk_beat(tag, 1, 1, 'h0100, 2, 0);
        chk_beat(tag, 1, 2, 'h0200, 1, 0);
        chk_beat(tag, 1, 3, 'h0300, 0, 1);
    endtask

    task automatic send_frame(input logic [N*DW-1:0] f);
        in_data  = f;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset held with a frame offered.
        repeat (4) step();
        chk("rst_out_data", int'(out_data[0]), 0);
        chk("rst_out_sel", int'(out_sel[0]), 0);
        chk("rst_in_ready", int'(in_ready[1]), 1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Unstalled frame.
        clear_log();
        out_ready = 1'b1;
        send_frame(FRAME_A);
        repeat (8) step();
        chk_frame_a("plain");

        // Alternating backpressure with input data churning during the stream.
        clear_log();
        send_frame(FRAME_A);
        for (int c = 0; c < 16; c++) begin
            out_ready = (c % 2 == 0);
            in_data   = {$urandom, $urandom};
            step();
        end
        out_ready = 1'b1;
        step();
        chk_frame_a("stall");

        // Reset after two accepted beats.
        clear_log();
        send_frame(FRAME_A);
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", int'(out_valid[0]), 0);
        chk("midrst_sel", int'(out_sel[1]), 0);
        repeat (2) step();
        chk("midrst_beats", log_n[0], 2);
        chk("midrst_done", done_cnt[0] + done_cnt[1], 0);
        rst_n = 1'b1;
        step();
        clear_log();
        send_frame(FRAME_B);
        repeat (6) step();
        chk("after_count", log_n[0], 4);
        chk_beat("after", 0, 0, 'h0ddd, 0, 0);
        chk_beat("after", 1, 0, 'h0aaa, 3, 0);

`ifdef MUX_SEQ_MASK_EN
        clear_log();
        ch_mask = 4'b1010;
        send_frame(FRAME_A);
        repeat (6) step();
        chk("mask_count0", log_n[0], 2);
        chk("mask_count1", log_n[1], 2);
        chk_beat("mask", 0, 0, 'h0200, 1, 0);
        chk_beat("mask", 0, 1, 'h0000, 3, 1);
        chk_beat("mask", 1, 0, 'h0000, 3, 0);
        chk_beat("mask", 1, 1, 'h0200, 1, 1);
        chk("mask_done", done_cnt[0], 1);

        clear_log();
        ch_mask = 4'b0000;
        send_frame(FRAME_A);
        chk("zmask_done_pulse", int'(frame_done[0]), 1);
        chk("zmask_no_valid", int'(out_valid[0]), 0);
        step();
        chk("zmask_done_low", int'(frame_done[0]), 0);
        repeat (3) step();
        chk("zmask_beats", log_n[0] + log_n[1], 0);
        ch_mask = 4'b1111;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
